axi_rd_slv_mem: RTL and testbench



---
 rtl/axi_rd_slv_mem.sv | 127 ++++++++++++
 tb/tb_axi_rd_slv_mem.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_slv_mem.sv
// AXI read-channel responder serving bursts from a one-cycle-latency 64-bit memory.
// Define AXI_RD_SLV_RESP_CHK_EN to enable DECERR/SLVERR response checking.
module axi_rd_slv_mem #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [3:0]        RID,
  output logic [DWIDTH-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RUSER,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  localparam logic [1:0] M_FIXED = 2'd0, M_INCR = 2'd1, M_WRAP = 2'd2;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] wa, wa_step, ar_wa, wrap_mask;
  logic [3:0]        len_q, beat_cnt;
  logic [1:0]        mode_q, ar_mode, ar_resp;
  logic              decerr_q, ar_decerr, wrap_ok, last, ar_hs, unused_ok;
  logic [DWIDTH-1:0] rdata_q;

  assign ar_wa   = ARADDR[AWIDTH+2:3];
  assign wrap_ok = (ARLEN == 4'd1) || (ARLEN == 4'd3) || (ARLEN == 4'd7) || (ARLEN == 4'd15);
  assign ar_hs   = (state == IDLE) && ARVALID && !rst;
  assign last    = (beat_cnt == len_q);

  // Reserved burst type and illegal WRAP lengths fall back to INCR
  always_comb begin
    ar_mode = M_INCR;
    if (ARBURST == 2'b00)                ar_mode = M_FIXED;
    else if (ARBURST == 2'b10 && wrap_ok) ar_mode = M_WRAP;
  end

`ifdef AXI_RD_SLV_RESP_CHK_EN
  logic slverr;
  assign ar_decerr = |(ARADDR >> (AWIDTH + 3));
  assign slverr    = (ARSIZE != 3'd3) || (ARBURST == 2'b11) || (ARBURST == 2'b10 && !wrap_ok);
  assign ar_resp   = ar_decerr ? 2'b11 : (slverr ? 2'b10 : 2'b00);
  assign unused_ok = ^ARADDR[2:0];
`else
  assign ar_decerr = 1'b0;
  assign ar_resp   = 2'b00;
  assign unused_ok = ^{ARSIZE, ARADDR[31:AWIDTH+3], ARADDR[2:0]};
`endif

  // WRAP: len_q is 2^k-1, so it doubles as the mask of the wrapping low bits
  assign wrap_mask = AWIDTH'(len_q);
  always_comb begin
    case (mode_q)
      M_FIXED: wa_step = wa;
      M_WRAP:  wa_step = (wa & ~wrap_mask) | ((wa + AWIDTH'(1)) & wrap_mask);
      default: wa_step = wa + AWIDTH'(1);
    endcase
  end

  // mem_raddr looks one cycle ahead so the word is on mem_rdata during FETCH
  always_comb begin
    state_nxt = state;
    mem_raddr = wa;
    case (state)
      IDLE:  if (ARVALID) begin
               state_nxt = FETCH;
               mem_raddr = ar_wa;
             end
      FETCH: state_nxt = DATA;
      DATA:  if (RREADY) begin
               if (last) state_nxt = IDLE;
               else begin
                 state_nxt = FETCH;
                 mem_raddr = wa_step;
               end
             end
      default: state_nxt = IDLE;
    endcase
    if (rst) mem_raddr = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wa       <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      mode_q   <= M_INCR;
      RID      <= '0;
      RRESP    <= '0;
      decerr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (ar_hs) begin
        RID      <= ARID;
        len_q    <= ARLEN;
        mode_q   <= ar_mode;
        beat_cnt <= '0;
        wa       <= ar_wa;
        RRESP    <= ar_resp;
        decerr_q <= ar_decerr;
      end
      if (state == FETCH) rdata_q <= mem_rdata;
      if (state == DATA && RREADY && !last) begin
        beat_cnt <= beat_cnt + 4'd1;
        wa       <= wa_step;
      end
    end
  end

  assign ARREADY = (state == IDLE) && !rst;
  assign RVALID  = (state == DATA);
  assign RLAST   = RVALID && last;
  assign RDATA   = decerr_q ? '0 : rdata_q;
  assign RUSER   = 1'b0;
endmodule

// File: tb/tb_axi_rd_slv_mem.sv
// Directed bench for axi_rd_slv_mem with a one-cycle-latency memory model.
module tb_axi_rd_slv_mem;
  localparam int AW = 6;
`ifdef AXI_RD_SLV_RESP_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk, rst;
  logic [3:0]  ARID, ARLEN, RID;
  logic [31:0] ARADDR;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST, RRESP;
  logic        ARVALID, ARREADY, RLAST, RUSER, RVALID, RREADY;
  logic [63:0] RDATA, mem_rdata;
  logic [AW-1:0] mem_raddr;
  logic [63:0] mem [64];
  int tests = 0, fails = 0;

  axi_rd_slv_mem #(.DWIDTH(64), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER), .RVALID(RVALID), .RREADY(RREADY),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  function automatic logic [63:0] wd(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {16'hC0DE, v, 16'h5A5A, ~v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = size; ARVALID = 1'b1;
    #1 chk("arready", ARREADY, 1);
    @(posedge clk);
    #1 ARVALID = 1'b0;
  endtask

  task automatic get_beat(input string tag, input logic [63:0] data, input logic lst,
                          input logic [1:0] resp, input logic [3:0] id, input int stall,
                          input logic [AW-1:0] word);
    int n = 0;
    @(negedge clk);
    while (!RVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " rvalid"}, RVALID, 1);
    chk({tag, " rdata"}, RDATA, data);
    chk({tag, " rlast"}, RLAST, lst);
    chk({tag, " rresp"}, RRESP, resp);
    chk({tag, " rid"}, RID, id);
    chk({tag, " arready busy"}, ARREADY, 0);
    if (stall > 0) begin
      RREADY = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        chk({tag, " hold rvalid"}, RVALID, 1);
        chk({tag, " hold rdata"}, RDATA, data);
        chk({tag, " hold rlast"}, RLAST, lst);
        chk({tag, " hold rid"}, RID, id);
        chk({tag, " hold raddr"}, mem_raddr, word);
      end
      RREADY = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic end_burst(input string tag);
    @(negedge clk);
    chk({tag, " idle rvalid"}, RVALID, 0);
    chk({tag, " idle arready"}, ARREADY, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = wd(i);
    rst = 1'b1; RREADY = 1'b1; ARVALID = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd3; ARBURST = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst arready", ARREADY, 0);
    chk("rst rvalid", RVALID, 0);
    chk("rst rlast", RLAST, 0);
    chk("rst rid", RID, 0);
    chk("rst rdata", RDATA, 0);
    chk("rst rresp", RRESP, 0);
    chk("rst ruser", RUSER, 0);
    chk("rst raddr", mem_raddr, 0);
    rst = 1'b0;
    #1 chk("arready after rst", ARREADY, 1);

    // INCR from word 2, checks two-cycle latency
    send_ar(4'hA, 32'h10, 4'd3, 2'b01, 3'd3);
    @(negedge clk);
    chk("b1 fetch rvalid", RVALID, 0);
    chk("b1 fetch raddr", mem_raddr, 2);
    get_beat("b1 w2", wd(2), 0, 2'b00, 4'hA, 0, 2);
    get_beat("b1 w3", wd(3), 0, 2'b00, 4'hA, 0, 3);
    get_beat("b1 w4", wd(4), 0, 2'b00, 4'hA, 0, 4);
    get_beat("b1 w5", wd(5), 1, 2'b00, 4'hA, 0, 5);
    end_burst("b1");

    // WRAP 4 from word 7 -> 7,4,5,6
    send_ar(4'h2, 32'h38, 4'd3, 2'b10, 3'd3);
    get_beat("wrap w7", wd(7), 0, 2'b00, 4'h2, 0, 7);
    get_beat("wrap w4", wd(4), 0, 2'b00, 4'h2, 0, 4);
    get_beat("wrap w5", wd(5), 0, 2'b00, 4'h2, 0, 5);
    get_beat("wrap w6", wd(6), 1, 2'b00, 4'h2, 0, 6);
    end_burst("wrap");

    // INCR across top of memory, then FIXED
    send_ar(4'h3, 32'h1F8, 4'd1, 2'b01, 3'd3);
    get_beat("top w63", wd(63), 0, 2'b00, 4'h3, 0, 63);
    get_beat("top w0", wd(0), 1, 2'b00, 4'h3, 0, 0);
    end_burst("top");
    send_ar(4'h4, 32'h08, 4'd2, 2'b00, 3'd3);
    get_beat("fix a", wd(1), 0, 2'b00, 4'h4, 0, 1);
    get_beat("fix b", wd(1), 0, 2'b00, 4'h4, 0, 1);
    get_beat("fix c", wd(1), 1, 2'b00, 4'h4, 0, 1);
    end_burst("fix");

    // Backpressure on beat 2
    send_ar(4'h5, 32'h100, 4'd3, 2'b01, 3'd3);
    get_beat("bp w32", wd(32), 0, 2'b00, 4'h5, 0, 32);
    get_beat("bp w33", wd(33), 0, 2'b00, 4'h5, 5, 33);
    get_beat("bp w34", wd(34), 0, 2'b00, 4'h5, 0, 34);
    get_beat("bp w35", wd(35), 1, 2'b00, 4'h5, 0, 35);
    end_burst("bp");

    // Reset during beat 3 of a 16-beat burst
    send_ar(4'h6, 32'h0, 4'd15, 2'b01, 3'd3);
    get_beat("rm w0", wd(0), 0, 2'b00, 4'h6, 0, 0);
    get_beat("rm w1", wd(1), 0, 2'b00, 4'h6, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rm beat3 rvalid", RVALID, 1);
    chk("rm beat3 rdata", RDATA, wd(2));
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rm rvalid dropped", RVALID, 0);
    chk("rm rlast", RLAST, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rm arready", ARREADY, 1);
    send_ar(4'h9, 32'h20, 4'd0, 2'b01, 3'd3);
    get_beat("rm single", wd(4), 1, 2'b00, 4'h9, 0, 4);
    end_burst("rm");

    // Response checks (OKAY without the checker)
    send_ar(4'h1, 32'h0001_0000, 4'd0, 2'b01, 3'd3);
    get_beat("decerr", CHK ? 64'd0 : wd(0), 1, CHK ? 2'b11 : 2'b00, 4'h1, 0, 0);
    end_burst("decerr");
    send_ar(4'h7, 32'h18, 4'd0, 2'b01, 3'd2);
    get_beat("size2", wd(3), 1, CHK ? 2'b10 : 2'b00, 4'h7, 0, 3);
    end_burst("size2");
    send_ar(4'h8, 32'h28, 4'd2, 2'b10, 3'd3);
    get_beat("badwrap w5", wd(5), 0, CHK ? 2'b10 : 2'b00, 4'h8, 0, 5);
    get_beat("badwrap w6", wd(6), 0, CHK ? 2'b10 : 2'b00, 4'h8, 0, 6);
    get_beat("badwrap w7", wd(7), 1, CHK ? 2'b10 : 2'b00, 4'h8, 0, 7);
    end_burst("badwrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
